// File: rtl/cat_apb_frontend.sv
// APB3 slave front-end for the cat recognizer: control/status registers,
// image/weight memory write port, core start sequencing and verdict latch.
module cat_apb_frontend #(
    parameter int unsigned Amba_Word        = 24,
    parameter int unsigned Amba_Addr_Depth  = 13,
    parameter int unsigned Weight_precision = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Word-1:0]       PWDATA,
    output logic [Amba_Word-1:0]       PRDATA,
    output logic                       mem_we,
    output logic [Amba_Addr_Depth-1:0] mem_addr,
    output logic [Amba_Word-1:0]       mem_wdata,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic                       core_result,
    output logic                       CatRecOut
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [Amba_Word-1:0]         prdata_q, prdata_d;
    logic                         mem_we_q, mem_we_d;
    logic [Amba_Addr_Depth-1:0]   mem_addr_q, mem_addr_d;
    logic [Amba_Word-1:0]         mem_wdata_q, mem_wdata_d;
    logic                         core_start_q, core_start_d;
    logic                         cat_rec_out_q, cat_rec_out_d;
    logic                         done_q, done_d;
    logic                         result_q, result_d;
    logic                         err_q, err_d;
    logic [Weight_precision-1:0]  cfg_q, cfg_d;

    logic wr_commit;
    logic rd_setup;
    logic is_ctrl;
    logic is_status;
    logic is_cfg;
    logic is_mem;
    logic busy;
    logic start_req;

    // Bus decode
    always_comb begin
        wr_commit = PSEL & PENABLE & PWRITE;
        rd_setup  = PSEL & ~PENABLE & ~PWRITE;
        is_ctrl   = (PADDR == Amba_Addr_Depth'(0));
        is_status = (PADDR == Amba_Addr_Depth'(1));
        is_cfg    = (PADDR == Amba_Addr_Depth'(2));
        is_mem    = (PADDR >= Amba_Addr_Depth'(4));
        busy      = (state_q == ST_START) || (state_q == ST_BUSY);
        start_req = wr_commit & is_ctrl & PWDATA[0];
    end

    // Next-state, register file and output logic
    always_comb begin
        state_d       = state_q;
        prdata_d      = prdata_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        core_start_d  = 1'b0;
        cat_rec_out_d = cat_rec_out_q;
        done_d        = done_q;
        result_d      = result_q;
        err_d         = err_q;
        cfg_d         = cfg_q;

        if (rd_setup) begin
            if (is_status) begin
                prdata_d = Amba_Word'({err_q, result_q, done_q, busy});
            end else if (is_cfg) begin
                prdata_d = Amba_Word'(cfg_q);
            end else begin
                prdata_d = '0;
            end
        end

        if (wr_commit) begin
            if (start_req) begin
                if (busy) begin
                    err_d = 1'b1;
                end else begin
                    // A new run invalidates the previous verdict bits
                    state_d  = ST_START;
                    done_d   = 1'b0;
                    result_d = 1'b0;
                end
            end
            if (is_status) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
            if (is_cfg) begin
                cfg_d = PWDATA[Weight_precision-1:0];
            end
            if (is_mem) begin
                if (busy) begin
                    err_d = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = PADDR;
                    mem_wdata_d = PWDATA;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Verdict set takes priority over a same-cycle STATUS clear
                if (core_done) begin
                    state_d       = ST_DONE;
                    cat_rec_out_d = core_result;
                    done_d        = 1'b1;
                    result_d      = core_result;
                end
            end
            ST_DONE: begin
                if (!start_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prdata_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            core_start_q  <= 1'b0;
            cat_rec_out_q <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= 1'b0;
            err_q         <= 1'b0;
            cfg_q         <= '0;
        end else begin
            state_q       <= state_d;
            prdata_q      <= prdata_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            core_start_q  <= core_start_d;
            cat_rec_out_q <= cat_rec_out_d;
            done_q        <= done_d;
            result_q      <= result_d;
            err_q         <= err_d;
            cfg_q         <= cfg_d;
        end
    end

    assign PRDATA     = prdata_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_start = core_start_q;
    assign CatRecOut  = cat_rec_out_q;

endmodule

// File: tb/tb_cat_apb_frontend.sv
// Directed self-checking bench for cat_apb_frontend; inputs driven and
// outputs sampled on the falling edge.
module tb_cat_apb_frontend;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_start;
    logic          core_done;
    logic          core_result;
    logic          CatRecOut;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] rd;

    cat_apb_frontend #(
        .Amba_Word       (DW),
        .Amba_Addr_Depth (AW),
        .Weight_precision(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_start (core_start),
        .core_done  (core_done),
        .core_result(core_result),
        .CatRecOut  (CatRecOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge just after the commit edge
    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Captures PRDATA during the access cycle
    task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_done(input logic res);
        @(negedge clk);
        core_done = 1'b1; core_result = res;
        @(negedge clk);
        core_done = 1'b0; core_result = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; core_done = 1'b0; core_result = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_prdata", 32'(PRDATA), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_catrec", 32'(CatRecOut), 32'h0);
        rst = 1'b0;

        apb_read(AW'(1), rd);   check("rst_status", 32'(rd), 32'h0);
        apb_read(AW'(2), rd);   check("rst_cfg", 32'(rd), 32'h0);
        apb_read(AW'(3), rd);   check("rst_rsvd", 32'(rd), 32'h0);
        apb_read(AW'(100), rd); check("rst_mem_rd", 32'(rd), 32'h0);

        // Memory writes at low and top address
        apb_write(AW'(4), 24'h00ABCD);
        check("mw1_we", 32'(mem_we), 32'h1);
        check("mw1_addr", 32'(mem_addr), 32'd4);
        check("mw1_data", 32'(mem_wdata), 32'h00ABCD);
        @(negedge clk);
        check("mw1_we_low", 32'(mem_we), 32'h0);
        apb_write(AW'(8191), 24'hFFFFFF);
        check("mw2_we", 32'(mem_we), 32'h1);
        check("mw2_addr", 32'(mem_addr), 32'd8191);
        check("mw2_data", 32'(mem_wdata), 32'hFFFFFF);
        @(negedge clk);
        check("mw2_we_low", 32'(mem_we), 32'h0);

        // CFG masking, reserved and CTRL reads
        apb_write(AW'(2), 24'hFFFFFF);
        check("cfg_no_mem_we", 32'(mem_we), 32'h0);
        apb_read(AW'(2), rd); check("cfg_rd", 32'(rd), 32'h1F);
        apb_write(AW'(3), 24'h000123);
        apb_read(AW'(3), rd); check("rsvd_rd", 32'(rd), 32'h0);
        apb_read(AW'(2), rd); check("cfg_keep", 32'(rd), 32'h1F);
        apb_read(AW'(0), rd); check("ctrl_rd", 32'(rd), 32'h0);

        // Normal run with verdict 1
        apb_write(AW'(0), 24'h000001);
        check("start1_pulse", 32'(core_start), 32'h1);
        @(negedge clk);
        check("start1_low", 32'(core_start), 32'h0);
        apb_read(AW'(1), rd); check("busy_status", 32'(rd), 32'h1);
        check("start1_single", 32'(core_start), 32'h0);
        pulse_done(1'b1);
        check("verdict1", 32'(CatRecOut), 32'h1);
        apb_read(AW'(1), rd); check("done_status", 32'(rd), 32'h6);
        apb_write(AW'(1), 24'h000000);
        apb_read(AW'(1), rd); check("status_clr", 32'(rd), 32'h4);
        check("verdict1_hold", 32'(CatRecOut), 32'h1);

        // Errors while busy, then verdict 0
        apb_write(AW'(0), 24'h000001);
        check("start2_pulse", 32'(core_start), 32'h1);
        apb_write(AW'(10), 24'h00BEEF);
        check("busy_mem_drop", 32'(mem_we), 32'h0);
        @(negedge clk);
        check("busy_mem_drop2", 32'(mem_we), 32'h0);
        apb_write(AW'(0), 24'h000001);
        check("busy_no_start", 32'(core_start), 32'h0);
        @(negedge clk);
        check("busy_no_start2", 32'(core_start), 32'h0);
        apb_read(AW'(1), rd); check("err_status", 32'(rd), 32'h9);
        pulse_done(1'b0);
        check("verdict0", 32'(CatRecOut), 32'h0);
        apb_read(AW'(1), rd); check("done_err_status", 32'(rd), 32'hA);

        // Reset while busy; late core_done ignored
        apb_write(AW'(0), 24'h000001);
        check("start3_pulse", 32'(core_start), 32'h1);
        pulse_done(1'b1);
        apb_write(AW'(0), 24'h000001);
        check("start4_pulse", 32'(core_start), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy_catrec", 32'(CatRecOut), 32'h0);
        check("rst_busy_start", 32'(core_start), 32'h0);
        pulse_done(1'b1);
        check("late_done_ign", 32'(CatRecOut), 32'h0);
        apb_read(AW'(1), rd); check("rst_busy_status", 32'(rd), 32'h0);
        apb_read(AW'(2), rd); check("rst_cfg_clr", 32'(rd), 32'h0);
        apb_write(AW'(0), 24'h000001);
        check("fresh_start", 32'(core_start), 32'h1);

        // STATUS write in the same cycle as core_done: done wins, err cleared
        apb_write(AW'(20), 24'h000055);
        check("busy_mem_drop3", 32'(mem_we), 32'h0);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(1); PWDATA = '0;
        @(negedge clk);
        PENABLE = 1'b1; core_done = 1'b1; core_result = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; core_done = 1'b0; core_result = 1'b0;
        check("race_catrec", 32'(CatRecOut), 32'h1);
        apb_read(AW'(1), rd); check("race_status", 32'(rd), 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
